percent_display: RTL and testbench

Downstream consumer of the percentage divider: on each rising edge of the divider's `done` it captures the 7-bit `answer` and converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine. It then drives a time-multiplexed 4-digit common-anode 7-segment display with leading-zero blanking. The block sits between the divider and the board display pins.

---
 rtl/percent_display.sv | 108 ++++++++++
 tb/tb_percent_display.sv | 124 ++++++++++++
 2 files changed

// File: rtl/percent_display.sv
// percent_display: captures divider answers, converts them to BCD with double-dabble, and scans a 4-digit 7-segment display
module percent_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] answer,
  input  logic       done,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       busy,
  output logic       value_valid
);
  localparam int CW = $clog2(REFRESH_DIV);
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
  state_t state, state_n;
  logic done_q, trig, term, blank;
  logic [6:0] bin;
  logic [11:0] bcd, bcd_adj;
  logic [2:0] cnt;
  logic [3:0] hund, tens, ones, digit, an_n;
  logic [6:0] seg_n;
  logic [CW-1:0] refresh_cnt;
  logic [1:0] dig_sel;
  function automatic logic [3:0] add3(input logic [3:0] n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction
  assign trig = done & ~done_q;
  assign busy = state != IDLE;
  assign term = refresh_cnt == CW'(REFRESH_DIV - 1);
  assign bcd_adj = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
  // FSM state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  // next state: triggers only start a conversion from IDLE, 7 shifts, then one load cycle
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (trig ? SHIFT : IDLE) :
              state == SHIFT ? (cnt == 3'd6 ? LOAD : SHIFT) : IDLE;
  end
  // conversion datapath and displayed digit registers
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q <= 1'b0;
      bin <= '0;
      bcd <= '0;
      cnt <= '0;
      hund <= '0;
      tens <= '0;
      ones <= '0;
      value_valid <= 1'b0;
    end else begin
      done_q <= done;
      if (state == IDLE && trig) begin
        bin <= answer;
        bcd <= '0;
        cnt <= '0;
      end
      if (state == SHIFT) begin
        {bcd, bin} <= {bcd_adj[10:0], bin, 1'b0};
        cnt <= cnt + 3'd1;
      end
      if (state == LOAD) begin
        hund <= bcd[11:8];
        tens <= bcd[7:4];
        ones <= bcd[3:0];
        value_valid <= 1'b1;
      end
    end
  end
  // selected digit with leading-zero blanking; digit 3 is never lit
  always_comb begin
    digit = dig_sel == 2'd0 ? ones : dig_sel == 2'd1 ? tens : hund;
    blank = ~value_valid | dig_sel == 2'd3 | (dig_sel == 2'd2 & hund == 4'd0) |
            (dig_sel == 2'd1 & hund == 4'd0 & tens == 4'd0);
    an_n = blank ? 4'hF : ~(4'b0001 << dig_sel);
    seg_n = blank ? 7'h7F : seg_code(digit);
  end
  // refresh timer, digit scan and registered display pins
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt <= '0;
      dig_sel <= '0;
      an <= 4'hF;
      seg <= 7'h7F;
    end else begin
      refresh_cnt <= term ? '0 : refresh_cnt + 1'b1;
      dig_sel <= dig_sel + 2'(term);
      an <= an_n;
      seg <= seg_n;
    end
  end
endmodule

// File: tb/tb_percent_display.sv
// tb_percent_display: randomized and directed checks of percent_display against a behavioural model
module tb_percent_display;
  localparam int R = 4;
  logic clk = 0, reset = 1, done = 0, busy, value_valid;
  logic [6:0] answer = 0, seg;
  logic [3:0] an;
  int checks = 0, errors = 0;
  percent_display #(.REFRESH_DIV(R)) dut (
    .clk(clk), .reset(reset), .answer(answer), .done(done),
    .an(an), .seg(seg), .busy(busy), .value_valid(value_valid)
  );
  always #5 clk = ~clk;
  logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  int k, cnt, mval, d, h, t, o, dv;
  bit mdq, mvalid, bl, m_init = 0;
  logic [6:0] pend, e_seg;
  logic [3:0] e_an;
  bit e_busy;
  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  // model: decimal digits from integer arithmetic, 8-cycle conversion latency, scan slot from elapsed cycles
  always @(posedge clk) begin
    if (reset) begin
      k = 0; cnt = 0; mdq = 0; mval = 0; mvalid = 0; e_an = 4'hF; e_seg = 7'h7F;
    end else begin
      d = (k / R) % 4; h = mval / 100; t = (mval / 10) % 10; o = mval % 10;
      dv = d == 0 ? o : d == 1 ? t : h;
      bl = !mvalid || d == 3 || (d == 2 && h == 0) || (d == 1 && h == 0 && t == 0);
      e_an = bl ? 4'hF : ~(4'b0001 << d);
      e_seg = bl ? 7'h7F : segtab[dv];
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin mval = pend; mvalid = 1; end
      end else if (done && !mdq) begin
        pend = answer; cnt = 8;
      end
      mdq = done; k++;
    end
    e_busy = cnt > 0;
    m_init = 1;
  end
  always @(negedge clk)
    if (m_init) begin
      check("an", an, e_an);
      check("seg", seg, e_seg);
      check("busy", busy, e_busy);
      check("value_valid", value_valid, mvalid);
    end
  task automatic conv(input logic [6:0] v, input int hold);
    @(posedge clk); #2 answer = v; done = 1;
    @(posedge clk); #2 check("busy_start", busy, 1);
    repeat (hold - 1) @(posedge clk);
    #2 done = 0;
    repeat (9) @(posedge clk);
    #2 check("busy_end", busy, 0);
    check("valid_after", value_valid, 1);
  endtask
  task automatic scan(input string name, input logic [6:0] x0, input logic [6:0] x1, input logic [6:0] x2);
    logic [6:0] s0, s1, s2;
    bit lit3;
    s0 = 7'h7F; s1 = 7'h7F; s2 = 7'h7F; lit3 = 0;
    repeat (4 * R + 1) begin
      @(negedge clk);
      if (an == 4'b1110) s0 = seg;
      if (an == 4'b1101) s1 = seg;
      if (an == 4'b1011) s2 = seg;
      if (an == 4'b0111) lit3 = 1;
    end
    check({name, "_d0"}, s0, x0);
    check({name, "_d1"}, s1, x1);
    check({name, "_d2"}, s2, x2);
    check({name, "_d3"}, lit3, 0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #2 reset = 0;
    repeat (20) @(posedge clk);
    #2 check("reset_an", an, 4'hF);
    check("reset_seg", seg, 7'h7F);
    check("reset_valid", value_valid, 0);
    conv(42, 1);  scan("v42", 7'b0100100, 7'b0011001, 7'h7F);
    conv(100, 2); scan("v100", 7'b1000000, 7'b1000000, 7'b1111001);
    conv(7, 1);   scan("v7", 7'b1111000, 7'h7F, 7'h7F);
    conv(127, 3); scan("v127", 7'b1111000, 7'b0100100, 7'b1111001);
    conv(0, 1);   scan("v0", 7'b1000000, 7'h7F, 7'h7F);
    @(posedge clk); #2 answer = 42; done = 1;
    @(posedge clk); #2 done = 0;
    repeat (2) @(posedge clk);
    #2 answer = 55; done = 1;
    @(posedge clk); #2 done = 0;
    repeat (10) @(posedge clk);
    scan("drop", 7'b0100100, 7'b0011001, 7'h7F);
    conv(55, 50); scan("v55", 7'b0010010, 7'b0010010, 7'h7F);
    #2 reset = 1;
    @(posedge clk); #2 reset = 0;
    @(posedge clk); #2 answer = 88; done = 1;
    @(posedge clk); #2 done = 0;
    repeat (3) @(posedge clk);
    #2 reset = 1;
    @(posedge clk); #2 reset = 0;
    check("rst_busy", busy, 0);
    check("rst_valid", value_valid, 0);
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    repeat (12) @(posedge clk);
    #2 check("rst_valid_hold", value_valid, 0);
    conv(88, 1); scan("v88", 7'b0000000, 7'b0000000, 7'h7F);
    repeat (400) begin
      @(posedge clk);
      #2 answer = 7'($urandom_range(0, 127));
      if ($urandom % 6 == 0) done = ~done;
    end
    done = 0;
    repeat (4 * R + 12) @(posedge clk);
    #3 $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
